store_buffer: RTL

Posted-write buffer between the CPU memory stage and the data memory. Accepts word stores (write enable, address, data) from the memory stage in one cycle, queues them in a small FIFO, and drains them in order to a slower memory port over a req/ack handshake. A combinational load-forwarding path returns the youngest buffered data for a matching word address so loads observe pending stores. Raises `full_o` so the hazard unit can stall the pipeline.

---
 rtl/store_buffer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// Posted-write buffer between the CPU memory stage and the data memory.
// Word stores are accepted in one cycle and queued in a small circular FIFO.
// They drain in order to a slower memory port over a req/ack handshake.
// A combinational forwarding path returns the youngest buffered data for a
// matching word address, so loads see stores that are still pending.
//
// Parameters
//   DEPTH : number of entries (power of two, >= 2)
//   AW    : address width
//   DW    : data width
//
// Ports
//   clk, reset        : clock; synchronous active-high reset
//   we_i/addr_i/wdata_i
//                     : store request from the memory stage
//   full_o/empty_o/count_o
//                     : occupancy status (registered count only)
//   overflow_o        : sticky flag, set when a store arrives while full
//   ld_addr_i         : load address for the forwarding lookup
//   ld_hit_o/ld_data_o: forwarding result (data is 0 on a miss)
//   mem_req_o/mem_addr_o/mem_wdata_o
//                     : head entry offered to memory
//   mem_ack_i         : memory accepted the head entry this cycle
// -----------------------------------------------------------------------------
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we_i,
  input  logic [AW-1:0]            addr_i,
  input  logic [DW-1:0]            wdata_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                     overflow_o,
  input  logic [AW-1:0]            ld_addr_i,
  output logic                     ld_hit_o,
  output logic [DW-1:0]            ld_data_o,
  output logic                     mem_req_o,
  output logic [AW-1:0]            mem_addr_o,
  output logic [DW-1:0]            mem_wdata_o,
  input  logic                     mem_ack_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Clears the byte-offset bits so every comparison is on word addresses.
  localparam logic [AW-1:0] WORD_MASK = ~AW'(3);

  logic [AW-1:0] addr_mem_q [DEPTH];
  logic [DW-1:0] data_mem_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic push;
  logic pop;

  // ---------------------------------------------------------------------------
  // Status and handshake
  // ---------------------------------------------------------------------------
  assign full_o      = (count_q == CW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign overflow_o  = overflow_q;

  assign mem_req_o   = ~empty_o;
  assign mem_addr_o  = addr_mem_q[head_q];
  assign mem_wdata_o = data_mem_q[head_q];

  // full_o is the registered state before the edge, so a pop in the same
  // cycle never makes room for a store that arrives while full.
  assign push = we_i & ~full_o;
  assign pop  = mem_req_o & mem_ack_i;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first; a path that
    // leaves a variable unassigned would otherwise infer a latch.
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q | (we_i & full_o);

    // Pointers wrap naturally because DEPTH is a power of two.
    if (push) tail_d = tail_q + PW'(1);
    if (pop)  head_d = head_q + PW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: the entry storage is deliberately not reset; an entry is only ever
  // read while the count marks it occupied, and that count is reset.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      addr_mem_q[tail_q] <= addr_i & WORD_MASK;
      data_mem_q[tail_q] <= wdata_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Load forwarding
  // Walk occupied entries from oldest (head) to youngest; a later match
  // overrides an earlier one, so the youngest matching store wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [PW-1:0] idx;
    ld_hit_o  = 1'b0;
    ld_data_o = '0;
    idx       = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_mem_q[idx] == (ld_addr_i & WORD_MASK))) begin
        ld_hit_o  = 1'b1;
        ld_data_o = data_mem_q[idx];
      end
    end
  end

endmodule
